// File: rtl/conv_kern_stream_if.sv
// Beat, configuration and result bus for conv_kern_stream.
// master = front end / output writer side, slave = kernel side.
interface conv_kern_stream_if #(
    parameter int WI         = 8,
    parameter int LANES      = 144,
    parameter int PARAM_BITS = 16,
    parameter int ACT_BITS   = 8
) ();
    logic                  vld_i;
    logic                  rdy_i;
    logic [LANES*WI-1:0]   win;
    logic [LANES*WI-1:0]   din;
    logic [7:0]            cfg_beats;
    logic [1:0]            cfg_act;
    logic [PARAM_BITS-1:0] bias;
    logic [PARAM_BITS-1:0] scale;
    logic [5:0]            scale_shift;
    logic [ACT_BITS-1:0]   acc_o;
    logic                  vld_o;
    logic                  rdy_o;
    logic                  busy;

    modport master (
        output vld_i, win, din, cfg_beats, cfg_act, bias, scale, scale_shift, rdy_o,
        input  rdy_i, acc_o, vld_o, busy
    );

    modport slave (
        input  vld_i, win, din, cfg_beats, cfg_act, bias, scale, scale_shift, rdy_o,
        output rdy_i, acc_o, vld_o, busy
    );
endinterface

// File: rtl/conv_kern_stream.sv
// Generic power-of-two FIFO; head word is visible on rd_dat while rd_vld is high.
// Latency: write at one edge, readable after that edge.
// Backpressure: writer must respect count (no full guard); pop on rd_vld && rd_rdy.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    assign rd_vld = (count != '0);
    assign pop    = rd_vld && rd_rdy;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_vld) - (AW+1)'(pop);
        end
    end
endmodule

// LANES-wide signed dot-product accumulator with bias/scale/round/activation/saturate; CONV_KERN_LEAKY_EN enables leaky ReLU.
// Latency: last beat accepted at edge 0 -> result visible on vld_o/acc_o after edge 6.
// Backpressure: rdy_i credits FIFO slots against in-flight groups; output is valid/ready.
module conv_kern_stream #(
    parameter int WI          = 8,
    parameter int LANES       = 144,
    parameter int PARAM_BITS  = 16,
    parameter int ACC_BITS    = 32,
    parameter int ACT_BITS    = 8,
    parameter int OFIFO_DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    conv_kern_stream_if.slave  bus
);
    localparam int PW = 2 * WI;
    localparam int MW = ACC_BITS + PARAM_BITS;
    localparam int CW = $clog2(OFIFO_DEPTH) + 1;
    localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (ACT_BITS - 1)) - 64'sd1;
    localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (ACT_BITS - 1));

    logic [7:0] beat_cnt, beats_q, beats_cur, cnt_inc;
    logic [1:0] act_q, act_cur;
    logic       accept, first_beat, last_beat;

    logic                         s1_vld, s1_first, s1_last;
    logic signed [PW-1:0]         prod_q [LANES];
    logic [1:0]                   s1_act;
    logic signed [PARAM_BITS-1:0] s1_bias, s1_scale;
    logic [5:0]                   s1_sh;

    logic                         s2_vld, s2_first, s2_last;
    logic signed [ACC_BITS-1:0]   tree_sum, s2_sum;
    logic [1:0]                   s2_act;
    logic signed [PARAM_BITS-1:0] s2_bias, s2_scale;
    logic [5:0]                   s2_sh;

    logic                         acc_vld;
    logic signed [ACC_BITS-1:0]   acc_q;
    logic [1:0]                   a_act;
    logic signed [PARAM_BITS-1:0] a_bias, a_scale;
    logic [5:0]                   a_sh;

    logic                         p1_vld, p2_vld, p3_vld;
    logic signed [ACC_BITS-1:0]   p1_q;
    logic [1:0]                   p1_act, p2_act;
    logic signed [PARAM_BITS-1:0] p1_scale;
    logic [5:0]                   p1_sh, p2_sh;
    logic signed [MW-1:0]         p2_q;
    logic signed [ACT_BITS-1:0]   sat_val, p3_q;
    logic signed [63:0]           p2_wide, rnd, shifted, act_val;

    logic [CW-1:0] inflight, fifo_cnt;

    // Group config is taken live on the first beat and from the latched copy afterwards.
    always_comb begin
        accept     = bus.vld_i && bus.rdy_i;
        first_beat = (beat_cnt == 8'd0);
        beats_cur  = first_beat ? bus.cfg_beats : beats_q;
        act_cur    = first_beat ? bus.cfg_act : act_q;
        cnt_inc    = beat_cnt + 8'd1;
        last_beat  = (cnt_inc == beats_cur);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            beats_q  <= '0;
            act_q    <= '0;
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s2_vld   <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            acc_vld  <= 1'b0;
            p1_vld   <= 1'b0;
            p2_vld   <= 1'b0;
            p3_vld   <= 1'b0;
            inflight <= '0;
        end else begin
            if (accept) begin
                beat_cnt <= last_beat ? 8'd0 : cnt_inc;
                if (first_beat) begin
                    beats_q <= bus.cfg_beats;
                    act_q   <= bus.cfg_act;
                end
            end
            s1_vld   <= accept;
            s1_first <= first_beat;
            s1_last  <= last_beat;
            s2_vld   <= s1_vld;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            acc_vld  <= s2_vld && s2_last;
            p1_vld   <= acc_vld;
            p2_vld   <= p1_vld;
            p3_vld   <= p2_vld;
            inflight <= inflight + CW'(accept && last_beat) - CW'(p3_vld);
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < LANES; k++) tree_sum = tree_sum + ACC_BITS'(prod_q[k]);
    end

    // Datapath carries no reset; the valid chain above qualifies every stage.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < LANES; k++)
                prod_q[k] <= PW'($signed(bus.win[k*WI +: WI])) * PW'($signed(bus.din[k*WI +: WI]));
            s1_act   <= act_cur;
            s1_bias  <= bus.bias;
            s1_scale <= bus.scale;
            s1_sh    <= bus.scale_shift;
        end
        s2_sum   <= tree_sum;
        s2_act   <= s1_act;
        s2_bias  <= s1_bias;
        s2_scale <= s1_scale;
        s2_sh    <= s1_sh;
        if (s2_vld) acc_q <= s2_first ? s2_sum : acc_q + s2_sum;
        a_act    <= s2_act;
        a_bias   <= s2_bias;
        a_scale  <= s2_scale;
        a_sh     <= s2_sh;
        p1_q     <= acc_q + ACC_BITS'(a_bias);
        p1_act   <= a_act;
        p1_scale <= a_scale;
        p1_sh    <= a_sh;
        p2_q     <= MW'(p1_q) * MW'(p1_scale);
        p2_act   <= p1_act;
        p2_sh    <= p1_sh;
        p3_q     <= sat_val;
    end

    // 64-bit working width leaves headroom for the rounding term at any shift.
    always_comb begin
        p2_wide = 64'(p2_q);
        rnd     = (p2_sh == 6'd0) ? 64'sd0 : (64'sd1 <<< (p2_sh - 6'd1));
        shifted = (p2_wide + rnd) >>> p2_sh;
        act_val = shifted;
        if (p2_act != 2'd0 && shifted < 0) begin
`ifdef CONV_KERN_LEAKY_EN
            act_val = (p2_act == 2'd2) ? (shifted >>> 3) : 64'sd0;
`else
            act_val = 64'sd0;
`endif
        end
        if (act_val > SAT_MAX)      sat_val = SAT_MAX[ACT_BITS-1:0];
        else if (act_val < SAT_MIN) sat_val = SAT_MIN[ACT_BITS-1:0];
        else                        sat_val = act_val[ACT_BITS-1:0];
    end

    sync_fifo #(.W(ACT_BITS), .DEPTH(OFIFO_DEPTH)) u_ofifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (p3_vld),
        .wr_dat (p3_q),
        .rd_vld (bus.vld_o),
        .rd_rdy (bus.rdy_o),
        .rd_dat (bus.acc_o),
        .count  (fifo_cnt)
    );

    assign bus.rdy_i = ({1'b0, fifo_cnt} + {1'b0, inflight}) < (CW+1)'(OFIFO_DEPTH);
    assign bus.busy  = (beat_cnt != 8'd0) || (inflight != '0) || (fifo_cnt != '0);
endmodule

// File: tb/tb_conv_kern_stream.sv
// Randomised bench for conv_kern_stream against an arithmetic reference model.
module tb_conv_kern_stream;
    localparam int WI = 8, LANES = 144, PARAM_BITS = 16, ACC_BITS = 32, ACT_BITS = 8, OFIFO_DEPTH = 4;
    localparam int DW = LANES * WI;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_kern_stream_if #(.WI(WI), .LANES(LANES), .PARAM_BITS(PARAM_BITS), .ACT_BITS(ACT_BITS)) bus ();

    conv_kern_stream #(.WI(WI), .LANES(LANES), .PARAM_BITS(PARAM_BITS), .ACC_BITS(ACC_BITS),
                       .ACT_BITS(ACT_BITS), .OFIFO_DEPTH(OFIFO_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;
    int got_q[$];
    int exp_q[$];

    always @(negedge clk)
        if (!rst && bus.vld_o && bus.rdy_o) got_q.push_back(int'($signed(bus.acc_o)));

    function automatic logic [DW-1:0] splat(input logic [WI-1:0] v);
        logic [DW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*WI +: WI] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*WI +: WI] = WI'($urandom_range(0, 255));
        return r;
    endfunction

    function automatic int dot(input logic [DW-1:0] w, input logic [DW-1:0] d);
        int s = 0;
        logic signed [WI-1:0] a, b;
        for (int k = 0; k < LANES; k++) begin
            a = w[k*WI +: WI];
            b = d[k*WI +: WI];
            s += int'(a) * int'(b);
        end
        return s;
    endfunction

    // acc is the 32-bit wrapped group sum; everything after it is plain wide arithmetic.
    function automatic int model(input int acc, input int b, input int sc, input int sh, input int act);
        int     p1 = acc + b;
        longint v  = longint'(p1) * longint'(sc);
        if (sh != 0) v = (v + (longint'(1) <<< (sh - 1))) >>> sh;
        if (act != 0 && v < 0) begin
`ifdef CONV_KERN_LEAKY_EN
            v = (act == 2) ? (v >>> 3) : 0;
`else
            v = 0;
`endif
        end
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return int'(v);
    endfunction

    task automatic set_params(input int b, input int sc, input int sh);
        bus.bias        = PARAM_BITS'(b);
        bus.scale       = PARAM_BITS'(sc);
        bus.scale_shift = 6'(sh);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_beat(input logic [DW-1:0] w, input logic [DW-1:0] d, input int max_wait, output bit ok);
        int waited = 0;
        ok = 1'b0;
        bus.vld_i = 1'b1;
        bus.win   = w;
        bus.din   = d;
        while (!ok && waited < max_wait) begin
            @(negedge clk);
            ok = bus.rdy_i;
            @(posedge clk);
            #1;
            waited++;
        end
        bus.vld_i = 1'b0;
    endtask

    task automatic wait_outputs(input int n, input int limit);
        int c = 0;
        while (got_q.size() < n && c < limit) begin @(posedge clk); #1; c++; end
    endtask

    task automatic test_reset();
        checks++; if (bus.rdy_i !== 1'b1) begin failures++; $display("FAIL reset_rdy_i got=%0b exp=1", bus.rdy_i); end
        checks++; if (bus.vld_o !== 1'b0) begin failures++; $display("FAIL reset_vld_o got=%0b exp=0", bus.vld_o); end
        checks++; if (bus.acc_o !== 8'd0) begin failures++; $display("FAIL reset_acc_o got=%0d exp=0", bus.acc_o); end
        checks++; if (bus.busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    endtask

    task automatic test_saturation();
        bit ok1, ok2;
        logic [DW-1:0] ones = splat(8'd1);
        got_q.delete();
        bus.rdy_o = 1'b0; bus.cfg_beats = 8'd2; bus.cfg_act = 2'd0; set_params(0, 1, 0);
        send_beat(ones, ones, 10, ok1);
        send_beat(ones, ones, 10, ok2);
        checks++; if (!(ok1 && ok2)) begin failures++; $display("FAIL sat_accept got=%0b%0b exp=11", ok1, ok2); end
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (i == 5) begin
                checks++; if (bus.vld_o !== 1'b0) begin failures++; $display("FAIL sat_vld_early got=%0b exp=0", bus.vld_o); end
            end
        end
        checks++; if (bus.vld_o !== 1'b1) begin failures++; $display("FAIL sat_vld_edge6 got=%0b exp=1", bus.vld_o); end
        checks++; if ($signed(bus.acc_o) !== 8'sd127) begin failures++; $display("FAIL sat_value got=%0d exp=127", $signed(bus.acc_o)); end
        bus.rdy_o = 1'b1;
        wait_outputs(1, 20);
        idle(1);
        checks++; if (bus.busy !== 1'b0 || bus.vld_o !== 1'b0) begin
            failures++; $display("FAIL sat_drain got busy=%0b vld_o=%0b exp=0/0", bus.busy, bus.vld_o);
        end
    endtask

    task automatic test_negative();
        bit ok;
        logic [DW-1:0] w = splat(8'hFF);
        logic [DW-1:0] d = splat(8'd1);
        got_q.delete(); exp_q.delete();
        bus.rdy_o = 1'b1; bus.cfg_beats = 8'd1; set_params(0, 1, 0);
        exp_q.push_back(-128);
        exp_q.push_back(0);
`ifdef CONV_KERN_LEAKY_EN
        exp_q.push_back(-18);
`else
        exp_q.push_back(0);
`endif
        exp_q.push_back(0);
        for (int a = 0; a < 4; a++) begin
            bus.cfg_act = 2'(a);
            send_beat(w, d, 20, ok);
            checks++; if (!ok) begin failures++; $display("FAIL neg_accept act=%0d got=0 exp=1", a); end
        end
        wait_outputs(4, 50);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL neg_act%0d got=%0d exp=%0d", i, (i < got_q.size()) ? got_q[i] : 9999, exp_q[i]);
            end
        end
    endtask

    task automatic test_rounding();
        bit ok;
        logic [DW-1:0] ones = splat(8'd1);
        got_q.delete(); exp_q.delete();
        bus.rdy_o = 1'b1; bus.cfg_beats = 8'd1; bus.cfg_act = 2'd0;
        set_params(16, 3, 6); send_beat(ones, ones, 20, ok); exp_q.push_back(8);
        set_params(16, 3, 0); send_beat(ones, ones, 20, ok); exp_q.push_back(127);
        wait_outputs(2, 50);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL round%0d got=%0d exp=%0d", i, (i < got_q.size()) ? got_q[i] : 9999, exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n_acc = 0;
        logic [DW-1:0] w [6];
        logic [DW-1:0] d [6];
        int b [6], sc [6], sh [6], act [6];
        got_q.delete(); exp_q.delete();
        bus.rdy_o = 1'b0; bus.cfg_beats = 8'd1;
        for (int g = 0; g < 6; g++) begin
            w[g] = rand_vec(); d[g] = rand_vec();
            b[g] = int'($urandom_range(0, 2000)) - 1000;
            sc[g] = int'($urandom_range(0, 30)) - 15;
            sh[g] = int'($urandom_range(4, 16));
            act[g] = int'($urandom_range(0, 3));
            exp_q.push_back(model(dot(w[g], d[g]), b[g], sc[g], sh[g], act[g]));
        end
        for (int g = 0; g < 5; g++) begin
            bus.cfg_act = 2'(act[g]); set_params(b[g], sc[g], sh[g]);
            send_beat(w[g], d[g], 15, ok);
            if (ok) n_acc++;
        end
        checks++; if (n_acc !== 4) begin failures++; $display("FAIL bp_accepted got=%0d exp=4", n_acc); end
        checks++; if (bus.rdy_i !== 1'b0) begin failures++; $display("FAIL bp_rdy_i got=%0b exp=0", bus.rdy_i); end
        checks++; if (bus.vld_o !== 1'b1 || int'($signed(bus.acc_o)) !== exp_q[0]) begin
            failures++; $display("FAIL bp_hold got vld=%0b acc=%0d exp 1/%0d", bus.vld_o, $signed(bus.acc_o), exp_q[0]);
        end
        bus.rdy_o = 1'b1;
        for (int g = 4; g < 6; g++) begin
            bus.cfg_act = 2'(act[g]); set_params(b[g], sc[g], sh[g]);
            send_beat(w[g], d[g], 30, ok);
            checks++; if (!ok) begin failures++; $display("FAIL bp_resume%0d got=0 exp=1", g); end
        end
        wait_outputs(6, 100);
        idle(10);
        checks++; if (got_q.size() !== 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", got_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL bp_out%0d got=%0d exp=%0d", i, (i < got_q.size()) ? got_q[i] : 9999, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n_bad = 0;
        logic [DW-1:0] w, d;
        int b, sc, sh, act;
        got_q.delete(); exp_q.delete();
        bus.rdy_o = 1'b1; bus.cfg_beats = 8'd1;
        for (int g = 0; g < 20; g++) begin
            w = rand_vec(); d = rand_vec();
            b = int'($urandom_range(0, 2000)) - 1000;
            sc = int'($urandom_range(0, 30)) - 15;
            sh = int'($urandom_range(0, 16));
            act = int'($urandom_range(0, 3));
            bus.cfg_act = 2'(act); set_params(b, sc, sh);
            send_beat(w, d, 20, ok);
            if (!ok) n_bad++;
            exp_q.push_back(model(dot(w, d), b, sc, sh, act));
        end
        checks++; if (n_bad !== 0) begin failures++; $display("FAIL b2b_accept got=%0d stalls exp=0", n_bad); end
        wait_outputs(20, 100);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL b2b_out%0d got=%0d exp=%0d", i, (i < got_q.size()) ? got_q[i] : 9999, exp_q[i]);
            end
        end
    endtask

    task automatic test_gapped_wrap();
        bit ok;
        int n_bad = 0, sum = 0, act0, b, sc, sh, c = 0;
        logic [DW-1:0] w, d;
        got_q.delete();
        bus.rdy_o = 1'b0; bus.cfg_beats = 8'd0;
        act0 = int'($urandom_range(0, 3)); bus.cfg_act = 2'(act0);
        b = int'($urandom_range(0, 2000)) - 1000;
        sc = int'($urandom_range(0, 30)) - 15;
        sh = int'($urandom_range(16, 24));
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            if (i == 1) begin bus.cfg_beats = 8'd3; bus.cfg_act = 2'(act0 + 1); end
            if (i == 255) set_params(b, sc, sh);
            else set_params(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), int'($urandom_range(0, 63)));
            w = rand_vec(); d = rand_vec();
            send_beat(w, d, 10, ok);
            if (!ok) n_bad++;
            sum += dot(w, d);
            if (i == 128) begin
                checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL wrap_busy_mid got=%0b exp=1", bus.busy); end
            end
        end
        checks++; if (n_bad !== 0) begin failures++; $display("FAIL wrap_accept got=%0d stalls exp=0", n_bad); end
        while (!bus.vld_o && c < 20) begin @(posedge clk); #1; c++; end
        checks++; if (bus.vld_o !== 1'b1 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL wrap_pending got vld=%0b busy=%0b exp 1/1", bus.vld_o, bus.busy);
        end
        bus.rdy_o = 1'b1;
        wait_outputs(1, 20);
        idle(1);
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== model(sum, b, sc, sh, act0)) begin
            failures++; $display("FAIL wrap_value got=%0d n=%0d exp=%0d", (got_q.size() > 0) ? got_q[0] : 9999, got_q.size(), model(sum, b, sc, sh, act0));
        end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL wrap_busy_end got=%0b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n_bad = 0, sum = 0, b, sc, sh;
        logic [DW-1:0] w, d;
        got_q.delete();
        bus.rdy_o = 1'b1; bus.cfg_beats = 8'd5; bus.cfg_act = 2'd0;
        for (int i = 0; i < 3; i++) begin
            w = rand_vec(); d = rand_vec();
            send_beat(w, d, 10, ok);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.rdy_i !== 1'b1 || bus.vld_o !== 1'b0 || bus.acc_o !== 8'd0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_outputs got rdy=%0b vld=%0b acc=%0d busy=%0b exp 1/0/0/0", bus.rdy_i, bus.vld_o, bus.acc_o, bus.busy);
        end
        b = int'($urandom_range(0, 2000)) - 1000;
        sc = int'($urandom_range(0, 30)) - 15;
        sh = int'($urandom_range(8, 18));
        set_params(b, sc, sh);
        for (int i = 0; i < 5; i++) begin
            w = rand_vec(); d = rand_vec();
            send_beat(w, d, 10, ok);
            if (!ok) n_bad++;
            sum += dot(w, d);
        end
        wait_outputs(1, 30);
        idle(10);
        checks++;
        if (n_bad !== 0 || got_q.size() !== 1 || got_q[0] !== model(sum, b, sc, 0 + sh, 0)) begin
            failures++; $display("FAIL rstmid_value got=%0d n=%0d exp=%0d", (got_q.size() > 0) ? got_q[0] : 9999, got_q.size(), model(sum, b, sc, sh, 0));
        end
    endtask

    initial begin
        bus.vld_i = 1'b0; bus.win = '0; bus.din = '0;
        bus.cfg_beats = 8'd1; bus.cfg_act = 2'd0;
        bus.bias = '0; bus.scale = 16'd1; bus.scale_shift = 6'd0; bus.rdy_o = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_saturation();
        test_negative();
        test_rounding();
        test_backpressure();
        test_back_to_back();
        test_gapped_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
